// File: rtl/vx_smem_pkg.sv
// Shared-memory responder helpers: address-split widths derived from SIZE/NUM_BANKS.
package vx_smem_pkg;

   localparam int unsigned WORD_BYTES = 4;

   // Integer log2 of a power-of-two value.
   function automatic int unsigned log2u(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r++;
      return r;
   endfunction

   // Bank-select width taken from the low word-address bits.
   function automatic int unsigned bank_bits(input int unsigned num_banks);
      return log2u(num_banks);
   endfunction

   // Word-address width covering the whole scratchpad.
   function automatic int unsigned word_bits(input int unsigned size);
      return log2u(size / WORD_BYTES);
   endfunction

   // Per-bank row-address width.
   function automatic int unsigned row_bits(input int unsigned size, input int unsigned num_banks);
      return word_bits(size) - bank_bits(num_banks);
   endfunction

endpackage

// File: rtl/vx_smem_bank.sv
// One scratchpad bank: synchronous single-port SRAM, byte-enable write, registered read.
module vx_smem_bank #(
   parameter int unsigned ROWS  = 1024,
   parameter int unsigned ROW_W = 10
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [ROW_W-1:0] row,
   input  logic [3:0]       byteen,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [ROWS];

   // Either a byte-masked write or a read into the output register, never both.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int unsigned b = 0; b < 4; b++) begin
               if (byteen[b]) mem[row][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end else begin
            rdata <= mem[row];
         end
      end
   end

endmodule

// File: rtl/vx_smem_responder.sv
// Banked shared-memory responder: lane arbitration, bank crossbar, merged load responses.
module vx_smem_responder
   import vx_smem_pkg::*;
#(
   parameter int unsigned NUM_THREADS = 4,
   parameter int unsigned NUM_BANKS   = 4,
   parameter int unsigned SIZE        = 16384,
   parameter int unsigned TAG_WIDTH   = 16,
   parameter int unsigned RSPQ_SIZE   = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_THREADS-1:0]         req_valid,
   input  logic [NUM_THREADS-1:0]         req_rw,
   input  logic [NUM_THREADS*32-1:0]      req_addr,
   input  logic [NUM_THREADS*4-1:0]       req_byteen,
   input  logic [NUM_THREADS*32-1:0]      req_data,
   input  logic [NUM_THREADS*TAG_WIDTH-1:0] req_tag,
   output logic [NUM_THREADS-1:0]         req_ready,
   output logic                           rsp_valid,
   output logic [NUM_THREADS-1:0]         rsp_tmask,
   output logic [NUM_THREADS*32-1:0]      rsp_data,
   output logic [TAG_WIDTH-1:0]           rsp_tag,
   input  logic                           rsp_ready
);

   localparam int unsigned BANK_W = bank_bits(NUM_BANKS);
   localparam int unsigned ROW_W  = row_bits(SIZE, NUM_BANKS);
   localparam int unsigned CRD_W  = $clog2(RSPQ_SIZE + 1);
   localparam int unsigned PTR_W  = $clog2(RSPQ_SIZE);

   typedef struct packed {
      logic [NUM_THREADS-1:0]    tmask;
      logic [NUM_THREADS*32-1:0] data;
      logic [TAG_WIDTH-1:0]      tag;
   } rsp_entry_t;

   logic [BANK_W-1:0]    lane_bank [NUM_THREADS];
   logic [ROW_W-1:0]     lane_row  [NUM_THREADS];
   logic                 lead_found, lead_rw;
   logic [TAG_WIDTH-1:0] lead_tag;
   logic [NUM_BANKS-1:0] bank_used;
   logic [NUM_THREADS-1:0] grant, fire;
   logic                 ld_fire;
   logic [CRD_W-1:0]     credits;

   logic [NUM_BANKS-1:0] bank_en, bank_we;
   logic [ROW_W-1:0]     bank_row   [NUM_BANKS];
   logic [3:0]           bank_be    [NUM_BANKS];
   logic [31:0]          bank_wdata [NUM_BANKS];
   logic [31:0]          bank_rdata [NUM_BANKS];

   logic                   ld_valid;
   logic [NUM_THREADS-1:0] ld_tmask;
   logic [TAG_WIDTH-1:0]   ld_tag;
   logic [BANK_W-1:0]      ld_bank [NUM_THREADS];
   logic [NUM_THREADS*32-1:0] push_data;

   rsp_entry_t           q_mem [RSPQ_SIZE];
   rsp_entry_t           q_head;
   logic [PTR_W-1:0]     q_wr, q_rd;
   logic [CRD_W-1:0]     q_cnt;
   logic                 rsp_fire;

   // Byte-offset and out-of-range address bits are deliberately ignored.
   logic unused_addr;
   assign unused_addr = ^req_addr;

   // Split each lane address into bank and row (address wraps modulo SIZE).
   always_comb begin
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
         lane_bank[i] = req_addr[i*32 + 2 +: BANK_W];
         lane_row[i]  = req_addr[i*32 + 2 + BANK_W +: ROW_W];
      end
   end

   // Leader selection and in-order bank-conflict grant; loads also need a credit.
   always_comb begin
      lead_found = 1'b0;
      lead_rw    = 1'b0;
      lead_tag   = '0;
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
         if (req_valid[i] && !lead_found) begin
            lead_found = 1'b1;
            lead_rw    = req_rw[i];
            lead_tag   = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
         end
      end
      bank_used = '0;
      grant     = '0;
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
         if (req_valid[i] && (req_tag[i*TAG_WIDTH +: TAG_WIDTH] == lead_tag) &&
             (req_rw[i] == lead_rw) && (lead_rw || (credits != '0)) &&
             !bank_used[lane_bank[i]]) begin
            grant[i]                  = 1'b1;
            bank_used[lane_bank[i]]   = 1'b1;
         end
      end
   end

   assign req_ready = reset ? grant : '0;
   assign fire      = req_ready & req_valid;
   assign ld_fire   = |(fire & ~req_rw);

   // Lane-to-bank crossbar: at most one granted lane drives each bank.
   always_comb begin
      bank_en = '0;
      bank_we = '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         bank_row[b]   = '0;
         bank_be[b]    = '0;
         bank_wdata[b] = '0;
      end
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
         if (fire[i]) begin
            bank_en[lane_bank[i]]    = 1'b1;
            bank_we[lane_bank[i]]    = req_rw[i];
            bank_row[lane_bank[i]]   = lane_row[i];
            bank_be[lane_bank[i]]    = req_byteen[i*4 +: 4];
            bank_wdata[lane_bank[i]] = req_data[i*32 +: 32];
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      vx_smem_bank #(
         .ROWS  (1 << ROW_W),
         .ROW_W (ROW_W)
      ) u_bank (
         .clk    (clk),
         .en     (bank_en[b]),
         .we     (bank_we[b]),
         .row    (bank_row[b]),
         .byteen (bank_be[b]),
         .wdata  (bank_wdata[b]),
         .rdata  (bank_rdata[b])
      );
   end

   // Flop load metadata alongside the bank read so the return mux lines up with rdata.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ld_valid <= 1'b0;
         ld_tmask <= '0;
         ld_tag   <= '0;
         for (int unsigned i = 0; i < NUM_THREADS; i++) ld_bank[i] <= '0;
      end else begin
         ld_valid <= ld_fire;
         if (ld_fire) begin
            ld_tmask <= fire;
            ld_tag   <= lead_tag;
            ld_bank  <= lane_bank;
         end
      end
   end

   // Bank-to-lane return mux; lanes not in the mask read as zero.
   always_comb begin
      push_data = '0;
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
         if (ld_tmask[i]) push_data[i*32 +: 32] = bank_rdata[ld_bank[i]];
      end
   end

   assign rsp_fire = rsp_valid && rsp_ready;

   // Response queue storage; occupancy is bounded by the credit counter.
   always_ff @(posedge clk) begin
      if (ld_valid) q_mem[q_wr] <= '{tmask: ld_tmask, data: push_data, tag: ld_tag};
   end

   // Queue pointers, occupancy and load credits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_wr    <= '0;
         q_rd    <= '0;
         q_cnt   <= '0;
         credits <= CRD_W'(RSPQ_SIZE);
      end else begin
         if (ld_valid) q_wr <= (q_wr == PTR_W'(RSPQ_SIZE - 1)) ? '0 : q_wr + PTR_W'(1);
         if (rsp_fire) q_rd <= (q_rd == PTR_W'(RSPQ_SIZE - 1)) ? '0 : q_rd + PTR_W'(1);
         case ({ld_valid, rsp_fire})
            2'b10:   q_cnt <= q_cnt + CRD_W'(1);
            2'b01:   q_cnt <= q_cnt - CRD_W'(1);
            default: ;
         endcase
         case ({ld_fire, rsp_fire})
            2'b10:   credits <= credits - CRD_W'(1);
            2'b01:   credits <= credits + CRD_W'(1);
            default: ;
         endcase
      end
   end

   assign q_head    = q_mem[q_rd];
   assign rsp_valid = (q_cnt != '0);
   assign rsp_tmask = rsp_valid ? q_head.tmask : '0;
   assign rsp_data  = rsp_valid ? q_head.data  : '0;
   assign rsp_tag   = rsp_valid ? q_head.tag   : '0;

endmodule

// File: tb/tb_vx_smem_responder.sv
// Directed bench for vx_smem_responder: grant table plus multi-cycle sequences.
module tb_vx_smem_responder;

   localparam int NT = 4;
   localparam int TW = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [NT-1:0]     req_valid, req_rw, req_ready;
   logic [NT*32-1:0]  req_addr, req_data;
   logic [NT*4-1:0]   req_byteen;
   logic [NT*TW-1:0]  req_tag;
   logic              rsp_valid, rsp_ready;
   logic [NT-1:0]     rsp_tmask;
   logic [NT*32-1:0]  rsp_data;
   logic [TW-1:0]     rsp_tag;

   int n_chk  = 0;
   int n_fail = 0;
   int cap_rd = 0;

   logic [NT-1:0]    cap_tmask [$];
   logic [NT*32-1:0] cap_data  [$];
   logic [TW-1:0]    cap_tag   [$];

   typedef struct packed {
      logic [3:0]   v;
      logic [3:0]   rw;
      logic [127:0] a;
      logic [63:0]  t;
      logic [3:0]   exp;
   } gvec_t;

   gvec_t gv [12];

   always #5 clk = ~clk;

   vx_smem_responder #(
      .NUM_THREADS (4),
      .NUM_BANKS   (4),
      .SIZE        (16384),
      .TAG_WIDTH   (16),
      .RSPQ_SIZE   (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_rw     (req_rw),
      .req_addr   (req_addr),
      .req_byteen (req_byteen),
      .req_data   (req_data),
      .req_tag    (req_tag),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_tmask  (rsp_tmask),
      .rsp_data   (rsp_data),
      .rsp_tag    (rsp_tag),
      .rsp_ready  (rsp_ready)
   );

   // Capture every accepted response, sampled mid-cycle ahead of the fire edge.
   always @(negedge clk) begin
      #2;
      if (reset && rsp_valid && rsp_ready) begin
         cap_tmask.push_back(rsp_tmask);
         cap_data.push_back(rsp_data);
         cap_tag.push_back(rsp_tag);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic clear_inputs();
      req_valid = '0; req_rw = '0; req_addr = '0;
      req_byteen = '0; req_data = '0; req_tag = '0;
   endtask

   task automatic set_lane(input int i, input logic rw, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] d, input logic [15:0] tg);
      req_valid[i]          = 1'b1;
      req_rw[i]             = rw;
      req_addr[i*32 +: 32]  = a;
      req_byteen[i*4 +: 4]  = be;
      req_data[i*32 +: 32]  = d;
      req_tag[i*TW +: TW]   = tg;
   endtask

   // Present the current requests for n cycles, checking ready per cycle and
   // withdrawing lanes that fired, as the LSU would.
   task automatic run_issue(input string nm, input logic [15:0] seq, input int n);
      logic [3:0] fired;
      for (int c = 0; c < n; c++) begin
         #1;
         chk($sformatf("%s ready c%0d", nm, c), req_ready, seq[c*4 +: 4]);
         fired = req_ready & req_valid;
         @(posedge clk);
         @(negedge clk);
         req_valid = req_valid & ~fired;
      end
      req_valid = '0;
   endtask

   task automatic wait_caps(input string nm, input int n);
      int budget = 20;
      while (cap_tag.size() < cap_rd + n && budget > 0) begin
         @(negedge clk);
         #3;
         budget--;
      end
      if (cap_tag.size() < cap_rd + n) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s wait: %0d responses seen, %0d required", nm, cap_tag.size() - cap_rd, n);
      end
      @(negedge clk);
   endtask

   task automatic expect_rsp(input string nm, input logic [3:0] tm, input logic [127:0] d, input logic [15:0] tg);
      n_chk++;
      if (cap_rd >= cap_tag.size()) begin
         n_fail++;
         $display("FAIL %s: no response, required tmask %b data %h tag %0d", nm, tm, d, tg);
      end else begin
         if (cap_tmask[cap_rd] !== tm || cap_data[cap_rd] !== d || cap_tag[cap_rd] !== tg) begin
            n_fail++;
            $display("FAIL %s: got tmask %b data %h tag %0d, required tmask %b data %h tag %0d",
                     nm, cap_tmask[cap_rd], cap_data[cap_rd], cap_tag[cap_rd], tm, d, tg);
         end
         cap_rd++;
      end
   endtask

   logic got;

   initial begin
      gv[0]  = '{4'b1111, 4'b0000, {32'hC,  32'h8,  32'h4,  32'h0},    {16'd5,16'd5,16'd5,16'd5}, 4'b1111};
      gv[1]  = '{4'b1111, 4'b0000, {32'h30, 32'h20, 32'h10, 32'h0},    {16'd5,16'd5,16'd5,16'd5}, 4'b0001};
      gv[2]  = '{4'b0110, 4'b0000, {32'h0,  32'h14, 32'h4,  32'h0},    {16'd5,16'd5,16'd5,16'd5}, 4'b0010};
      gv[3]  = '{4'b0011, 4'b0000, {32'h0,  32'h0,  32'h4,  32'h0},    {16'd0,16'd0,16'd2,16'd1}, 4'b0001};
      gv[4]  = '{4'b0111, 4'b0101, {32'h0,  32'h8,  32'h4,  32'h0},    {16'd5,16'd5,16'd5,16'd5}, 4'b0101};
      gv[5]  = '{4'b0000, 4'b0000, {32'h0,  32'h0,  32'h0,  32'h0},    {16'd5,16'd5,16'd5,16'd5}, 4'b0000};
      gv[6]  = '{4'b0011, 4'b0000, {32'h0,  32'h0,  32'h8,  32'h8},    {16'd5,16'd5,16'd5,16'd5}, 4'b0001};
      gv[7]  = '{4'b0011, 4'b0000, {32'h0,  32'h0,  32'h0,  32'h4000}, {16'd5,16'd5,16'd5,16'd5}, 4'b0001};
      gv[8]  = '{4'b0011, 4'b0000, {32'h0,  32'h0,  32'h6,  32'h1},    {16'd5,16'd5,16'd5,16'd5}, 4'b0011};
      gv[9]  = '{4'b1010, 4'b0000, {32'hC,  32'h0,  32'h4,  32'h0},    {16'd3,16'd0,16'd3,16'd0}, 4'b1010};
      gv[10] = '{4'b1111, 4'b1111, {32'h30, 32'h20, 32'h10, 32'h0},    {16'd5,16'd5,16'd5,16'd5}, 4'b0001};
      gv[11] = '{4'b1110, 4'b0000, {32'hC,  32'h8,  32'h4,  32'h0},    {16'd4,16'd4,16'd3,16'd0}, 4'b0010};

      // Reset state, with requests present
      reset = 1'b0;
      rsp_ready = 1'b1;
      clear_inputs();
      req_valid = 4'hF;
      req_tag = {4{16'd5}};
      repeat (2) @(negedge clk);
      #1;
      chk("reset req_ready", req_ready, 0);
      chk("reset rsp_valid", rsp_valid, 0);
      chk("reset rsp_tmask", rsp_tmask, 0);
      chk("reset rsp_data",  rsp_data,  0);
      chk("reset rsp_tag",   rsp_tag,   0);
      req_valid = '0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Combinational grant table (valid withdrawn before the edge, nothing fires)
      for (int k = 0; k < 12; k++) begin
         req_valid = gv[k].v; req_rw = gv[k].rw; req_addr = gv[k].a; req_tag = gv[k].t;
         req_byteen = '1; req_data = '0;
         #1;
         chk($sformatf("grant vec %0d", k), req_ready, gv[k].exp);
         req_valid = '0;
         @(negedge clk);
      end

      // 1: four-lane store then reload, single merged response two cycles later
      clear_inputs();
      for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 32'(i*4), 4'hF, 32'hA0 + 32'(i), 16'd5);
      run_issue("t1 store", 16'h000F, 1);
      for (int i = 0; i < 4; i++) set_lane(i, 1'b0, 32'(i*4), 4'hF, 32'h0, 16'd6);
      run_issue("t1 load", 16'h000F, 1);
      #1;
      chk("t1 rsp_valid T+1", rsp_valid, 0);
      @(negedge clk);
      #1;
      chk("t1 rsp_valid T+2", rsp_valid, 1);
      wait_caps("t1", 1);
      expect_rsp("t1 rsp", 4'b1111, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 16'd6);

      // 2: all lanes to bank 0 serialise, both for stores and loads
      clear_inputs();
      for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 32'(i*16), 4'hF, 32'hB0 + 32'(i), 16'd7);
      run_issue("t2 store", 16'h8421, 4);
      for (int i = 0; i < 4; i++) set_lane(i, 1'b0, 32'(i*16), 4'hF, 32'h0, 16'd8);
      run_issue("t2 load", 16'h8421, 4);
      wait_caps("t2", 4);
      expect_rsp("t2 rsp0", 4'b0001, {32'h0, 32'h0, 32'h0, 32'hB0}, 16'd8);
      expect_rsp("t2 rsp1", 4'b0010, {32'h0, 32'h0, 32'hB1, 32'h0}, 16'd8);
      expect_rsp("t2 rsp2", 4'b0100, {32'h0, 32'hB2, 32'h0, 32'h0}, 16'd8);
      expect_rsp("t2 rsp3", 4'b1000, {32'hB3, 32'h0, 32'h0, 32'h0}, 16'd8);

      // 3: differing tags never merge
      clear_inputs();
      set_lane(0, 1'b0, 32'h0, 4'hF, 32'h0, 16'd1);
      set_lane(1, 1'b0, 32'h4, 4'hF, 32'h0, 16'd2);
      run_issue("t3", 16'h0021, 2);
      wait_caps("t3", 2);
      expect_rsp("t3 rsp0", 4'b0001, {32'h0, 32'h0, 32'h0, 32'hB0}, 16'd1);
      expect_rsp("t3 rsp1", 4'b0010, {32'h0, 32'h0, 32'hA1, 32'h0}, 16'd2);

      // 4: partial byte-enable store, read back on the very next cycle
      clear_inputs();
      set_lane(0, 1'b1, 32'h40, 4'hF, 32'h11223344, 16'd3);
      run_issue("t4 store full", 16'h0001, 1);
      set_lane(0, 1'b1, 32'h40, 4'b0010, 32'h0000AA00, 16'd3);
      run_issue("t4 store byte", 16'h0001, 1);
      set_lane(0, 1'b0, 32'h40, 4'hF, 32'h0, 16'd9);
      run_issue("t4 load", 16'h0001, 1);
      wait_caps("t4", 1);
      expect_rsp("t4 rsp", 4'b0001, {96'h0, 32'h1122AA44}, 16'd9);

      // 5: credit exhaustion with responses back-pressured
      clear_inputs();
      rsp_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         set_lane(0, 1'b0, 32'(k*4), 4'hF, 32'h0, 16'(10 + k));
         run_issue($sformatf("t5 load%0d", k), 16'h0001, 1);
      end
      set_lane(2, 1'b1, 32'h80, 4'hF, 32'h5A, 16'd20);
      run_issue("t5 store no credit", 16'h0004, 1);
      #1;
      chk("t5 head valid", rsp_valid, 1);
      chk("t5 head tmask", rsp_tmask, 4'b0001);
      chk("t5 head tag",   rsp_tag,   16'd10);
      chk("t5 head data",  rsp_data,  {96'h0, 32'hB0});
      @(negedge clk);
      set_lane(0, 1'b0, 32'h40, 4'hF, 32'h0, 16'd14);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("t5 fifth stalled c%0d", c), req_ready, 0);
         @(negedge clk);
      end
      #1;
      chk("t5 hold valid", rsp_valid, 1);
      chk("t5 hold tag",   rsp_tag,   16'd10);
      chk("t5 hold data",  rsp_data,  {96'h0, 32'hB0});
      rsp_ready = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (req_ready[0]) got = 1'b1;
         @(posedge clk);
         @(negedge clk);
         if (got) break;
      end
      req_valid = '0;
      chk("t5 fifth granted", got, 1);
      wait_caps("t5", 5);
      expect_rsp("t5 rsp0", 4'b0001, {96'h0, 32'hB0},       16'd10);
      expect_rsp("t5 rsp1", 4'b0001, {96'h0, 32'hA1},       16'd11);
      expect_rsp("t5 rsp2", 4'b0001, {96'h0, 32'hA2},       16'd12);
      expect_rsp("t5 rsp3", 4'b0001, {96'h0, 32'hA3},       16'd13);
      expect_rsp("t5 rsp4", 4'b0001, {96'h0, 32'h1122AA44}, 16'd14);

      // 6: reset with queued loads drops them and restores full credit
      clear_inputs();
      rsp_ready = 1'b0;
      set_lane(0, 1'b0, 32'h0, 4'hF, 32'h0, 16'd30);
      run_issue("t6 load0", 16'h0001, 1);
      set_lane(0, 1'b0, 32'h4, 4'hF, 32'h0, 16'd31);
      run_issue("t6 load1", 16'h0001, 1);
      repeat (2) @(negedge clk);
      #1;
      chk("t6 queued valid", rsp_valid, 1);
      set_lane(0, 1'b0, 32'h8, 4'hF, 32'h0, 16'd32);
      reset = 1'b0;
      #1;
      chk("t6 reset req_ready", req_ready, 0);
      chk("t6 reset rsp_valid", rsp_valid, 0);
      chk("t6 reset rsp_tmask", rsp_tmask, 0);
      chk("t6 reset rsp_data",  rsp_data,  0);
      chk("t6 reset rsp_tag",   rsp_tag,   0);
      repeat (2) @(negedge clk);
      req_valid = '0;
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("t6 no stale c%0d", c), rsp_valid, 0);
         @(negedge clk);
      end
      set_lane(0, 1'b0, 32'h80, 4'hF, 32'h0, 16'd40);
      run_issue("t6 credit0", 16'h0001, 1);
      set_lane(0, 1'b0, 32'h0, 4'hF, 32'h0, 16'd41);
      run_issue("t6 credit1", 16'h0001, 1);
      set_lane(0, 1'b0, 32'h4, 4'hF, 32'h0, 16'd42);
      run_issue("t6 credit2", 16'h0001, 1);
      set_lane(0, 1'b0, 32'h8, 4'hF, 32'h0, 16'd43);
      run_issue("t6 credit3", 16'h0001, 1);
      set_lane(0, 1'b0, 32'hC, 4'hF, 32'h0, 16'd44);
      #1;
      chk("t6 credits exhausted", req_ready, 0);
      req_valid = '0;
      @(negedge clk);
      rsp_ready = 1'b1;
      wait_caps("t6", 4);
      expect_rsp("t6 rsp0", 4'b0001, {96'h0, 32'h5A}, 16'd40);
      expect_rsp("t6 rsp1", 4'b0001, {96'h0, 32'hB0}, 16'd41);
      expect_rsp("t6 rsp2", 4'b0001, {96'h0, 32'hA1}, 16'd42);
      expect_rsp("t6 rsp3", 4'b0001, {96'h0, 32'hA2}, 16'd43);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
